alu_out_stage: RTL and testbench
================================

ALU_OUT_STAGE -- requirements
Module: alu_out_stage

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of every data port and register.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream ALU transaction present.
REQ-005 in_ready  output  1  stage can accept a transaction this cycle.
REQ-006 in_wb  input  3  writeback kind: WB_NONE, WB_ALU, WB_HILO, WB_MFHI, WB_MFLO.
REQ-007 result  input  WIDTH  ALU low result.
REQ-008 result_hi  input  WIDTH  ALU high result (multiply upper half).
REQ-009 branch_taken  input  1  ALU branch condition.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  downstream consumes head entry.
REQ-012 out_data  output  WIDTH  head entry data.
REQ-013 out_branch  output  1  head entry branch flag.
REQ-014 hi_q  output  WIDTH  current HI register.
REQ-015 lo_q  output  WIDTH  current LO register.

Function
REQ-016 Accept occurs when in_valid and in_ready are both 1 on a rising edge; dequeue occurs when out_valid and out_ready are both 1.
REQ-017 Internal 2-entry in-order buffer of {data, branch}; in_ready = 1 when occupancy < 2, 0 when occupancy = 2, independent of out_ready (registered, no combinational path from out_ready).
REQ-018 Accepted WB_ALU enqueues {result, branch_taken}.
REQ-019 Accepted WB_MFHI enqueues {HI, 0}; WB_MFLO enqueues {LO, 0}; HI/LO value is that held before the accepting edge.
REQ-020 Accepted WB_HILO loads HI <= result_hi, LO <= result on that edge and enqueues nothing.
REQ-021 Accepted WB_NONE and any undefined in_wb code enqueue nothing and change no state.
REQ-022 Latency: an enqueueing accept at edge N gives out_valid = 1 after edge N when occupancy was 0.
REQ-023 out_valid = (occupancy > 0); out_data/out_branch always reflect the oldest entry; out_data = 0 and out_branch = 0 when empty.
REQ-024 Simultaneous enqueue and dequeue at occupancy 1: occupancy stays 1, new entry becomes head.
REQ-025 Enqueue-less accept (WB_HILO/WB_NONE) with simultaneous dequeue: occupancy decrements normally.
REQ-026 Head entry and out_valid hold stable while out_valid = 1 and out_ready = 0.
REQ-027 Dequeue when empty and accept when full are impossible by REQ-016/REQ-017; no state changes from such inputs.

Reset
REQ-028 rst_n = 0 asynchronously clears occupancy, both buffer entries, HI, LO; out_valid = 0, out_data = 0, out_branch = 0, hi_q = 0, lo_q = 0, in_ready = 1.
REQ-029 Reset mid-transfer discards all buffered entries; no partial entry survives; first accept after release behaves as from empty.

Configuration
REQ-030 Macro ALU_OUT_HILO_EN defined: HI/LO registers and REQ-019/REQ-020 behaviour present.
REQ-031 Macro ALU_OUT_HILO_EN undefined: no HI/LO storage; hi_q = lo_q = 0 always; WB_HILO behaves as WB_NONE; WB_MFHI/WB_MFLO enqueue {0, 0}.

Structure
REQ-032 Writeback-kind enum (wb_kind_t, 3 bits: WB_NONE=0, WB_ALU=1, WB_HILO=2, WB_MFHI=3, WB_MFLO=4) and default WIDTH constant live in shared package mips_pkg.
REQ-033 The 2-entry buffer is sub-module skid_fifo2 (parameterised width, push/pop/full/empty, async active-low reset); HI/LO and decode stay in alu_out_stage.

Verification
REQ-034 Reset, then WB_ALU result=0x0000_0005 branch=1, out_ready=1 -> next cycle out_valid=1, out_data=0x5, out_branch=1; following cycle out_valid=0.
REQ-035 out_ready=0, three back-to-back WB_ALU (0x11, 0x22, 0x33) -> first two accepted, in_ready=0 while full, 0x33 held; out_ready=1 drains 0x11, 0x22, 0x33 in order.
REQ-036 WB_HILO result_hi=0xDEAD_BEEF result=0x1234_5678, then WB_MFHI, WB_MFLO -> no entry for HILO; outputs 0xDEAD_BEEF then 0x1234_5678; hi_q/lo_q match.
REQ-037 Occupancy 1 (head 0xAA), simultaneous WB_ALU 0xBB accept and dequeue -> 0xAA consumed, head becomes 0xBB, occupancy 1.
REQ-038 Occupancy 2 and HI=0x7, assert rst_n=0 between edges -> out_valid, hi_q, lo_q immediately 0, in_ready=1; after release WB_MFHI yields 0x0.
REQ-039 Build without ALU_OUT_HILO_EN: WB_HILO 0xFFFF_FFFF then WB_MFLO -> out_data=0x0, hi_q=lo_q=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: writeback-kind encoding and default data width.
package mips_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    WB_NONE = 3'd0,
    WB_ALU  = 3'd1,
    WB_HILO = 3'd2,
    WB_MFHI = 3'd3,
    WB_MFLO = 3'd4
  } wb_kind_t;

endpackage

// File: rtl/alu_out_stage_if.sv
// ALU output stage bus: upstream ALU transaction, downstream result handshake, HI/LO view.
interface alu_out_stage_if #(
  parameter int unsigned WIDTH = mips_pkg::DATA_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_wb;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             branch_taken;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_branch;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  modport master (
    output in_valid, in_wb, result, result_hi, branch_taken, out_ready,
    input  in_ready, out_valid, out_data, out_branch, hi_q, lo_q
  );

  modport slave (
    input  in_valid, in_wb, result, result_hi, branch_taken, out_ready,
    output in_ready, out_valid, out_data, out_branch, hi_q, lo_q
  );
endinterface

// File: rtl/skid_fifo2.sv
// Two-entry in-order FIFO; head entry is always entry0, and empty slots read as zero.
module skid_fifo2 #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] entry0_q, entry0_d;
  logic [WIDTH-1:0] entry1_q, entry1_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign dout_o  = entry0_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d  = count_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) entry0_d = din_i;
        else                 entry1_d = din_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        entry0_d = entry1_q;
        entry1_d = '0;
        count_d  = count_q - 2'd1;
      end
      // push needs not-full and pop needs not-empty, so occupancy is exactly one here
      2'b11: begin
        entry0_d = din_i;
        entry1_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      count_q  <= count_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end
endmodule

// File: rtl/alu_out_stage.sv
// ALU output stage: writeback decode, optional HI/LO registers, 2-entry result buffer.
// Define ALU_OUT_HILO_EN to build the HI/LO registers; otherwise HI/LO read as zero.
module alu_out_stage
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_out_stage_if.slave bus
);
  logic             accept;
  logic             push;
  logic             pop;
  logic             load_hilo;
  logic [WIDTH-1:0] push_data;
  logic             push_branch;
  logic [WIDTH:0]   head;
  logic             full, empty;
  logic [WIDTH-1:0] hi_q, lo_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;

  always_comb begin
    push        = 1'b0;
    load_hilo   = 1'b0;
    push_data   = '0;
    push_branch = 1'b0;
    if (accept) begin
      case (bus.in_wb)
        WB_ALU: begin
          push        = 1'b1;
          push_data   = bus.result;
          push_branch = bus.branch_taken;
        end
        WB_MFHI: begin
          push      = 1'b1;
          push_data = hi_q;
        end
        WB_MFLO: begin
          push      = 1'b1;
          push_data = lo_q;
        end
        WB_HILO: load_hilo = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef ALU_OUT_HILO_EN
  logic [WIDTH-1:0] hi_d, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (load_hilo) begin
      hi_d = bus.result_hi;
      lo_d = bus.result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
`else
  // Without HI/LO storage, WB_HILO degenerates to WB_NONE and moves read zero.
  logic unused_hilo;
  assign unused_hilo = ^{load_hilo, bus.result_hi};
  assign hi_q = '0;
  assign lo_q = '0;
`endif

  skid_fifo2 #(
    .WIDTH(WIDTH + 1)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .din_i  ({push_data, push_branch}),
    .pop_i  (pop),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  assign bus.in_ready   = ~full;
  assign bus.out_valid  = ~empty;
  assign bus.out_data   = head[WIDTH:1];
  assign bus.out_branch = head[0];
  assign bus.hi_q       = hi_q;
  assign bus.lo_q       = lo_q;
endmodule

// File: tb/tb_alu_out_stage.sv
// Directed bench for alu_out_stage: cycle table plus reset and HI/LO-disabled sequences.
module tb_alu_out_stage;
  import mips_pkg::*;

  localparam int unsigned W = 32;
`ifdef ALU_OUT_HILO_EN
  localparam bit HILO = 1'b1;
`else
  localparam bit HILO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_out_stage_if #(.WIDTH(W)) bus ();

  alu_out_stage #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic        v;
    logic [2:0]  wb;
    logic [31:0] res;
    logic [31:0] rhi;
    logic        br;
    logic        ordy;
    logic        ev;
    logic [31:0] ed;
    logic        eb;
    logic        er;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t tab[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] hx(input logic [31:0] x);
    return HILO ? x : 32'h0;
  endfunction

  function automatic vec_t mk(input string name, input logic v, input logic [2:0] wb,
                              input logic [31:0] res, input logic [31:0] rhi, input logic br,
                              input logic ordy, input logic ev, input logic [31:0] ed,
                              input logic eb, input logic er, input logic [31:0] eh,
                              input logic [31:0] el);
    vec_t t;
    t.name = name; t.v = v; t.wb = wb; t.res = res; t.rhi = rhi; t.br = br; t.ordy = ordy;
    t.ev = ev; t.ed = ed; t.eb = eb; t.er = er; t.eh = eh; t.el = el;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input vec_t t);
    chk({t.name, ".out_valid"},  {31'b0, bus.out_valid},  {31'b0, t.ev});
    chk({t.name, ".out_data"},   bus.out_data,            t.ed);
    chk({t.name, ".out_branch"}, {31'b0, bus.out_branch}, {31'b0, t.eb});
    chk({t.name, ".in_ready"},   {31'b0, bus.in_ready},   {31'b0, t.er});
    chk({t.name, ".hi_q"},       bus.hi_q,                t.eh);
    chk({t.name, ".lo_q"},       bus.lo_q,                t.el);
  endtask

  task automatic apply(input vec_t t);
    @(negedge clk);
    bus.in_valid     = t.v;
    bus.in_wb        = t.wb;
    bus.result       = t.res;
    bus.result_hi    = t.rhi;
    bus.branch_taken = t.br;
    bus.out_ready    = t.ordy;
    @(posedge clk);
    #1;
    check_outs(t);
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_wb        = 3'd0;
    bus.result       = '0;
    bus.result_hi    = '0;
    bus.branch_taken = 1'b0;
    bus.out_ready    = 1'b0;

    //            name        v  wb       res           rhi           br ordy ev ed                 eb er eh             el
    tab.push_back(mk("alu5",    1, WB_ALU,  32'h5,        32'h0,        1, 1,  1, 32'h5,            1, 1, 0,             0));
    tab.push_back(mk("drain5",  0, WB_ALU,  32'h0,        32'h0,        0, 1,  0, 32'h0,            0, 1, 0,             0));
    tab.push_back(mk("push11",  1, WB_ALU,  32'h11,       32'h0,        0, 0,  1, 32'h11,           0, 1, 0,             0));
    tab.push_back(mk("push22",  1, WB_ALU,  32'h22,       32'h0,        0, 0,  1, 32'h11,           0, 0, 0,             0));
    tab.push_back(mk("hold33a", 1, WB_ALU,  32'h33,       32'h0,        1, 0,  1, 32'h11,           0, 0, 0,             0));
    tab.push_back(mk("hold33b", 1, WB_ALU,  32'h33,       32'h0,        1, 0,  1, 32'h11,           0, 0, 0,             0));
    tab.push_back(mk("pop11",   1, WB_ALU,  32'h33,       32'h0,        1, 1,  1, 32'h22,           0, 1, 0,             0));
    tab.push_back(mk("pp33",    1, WB_ALU,  32'h33,       32'h0,        1, 1,  1, 32'h33,           1, 1, 0,             0));
    tab.push_back(mk("pop33",   0, WB_ALU,  32'h0,        32'h0,        0, 1,  0, 32'h0,            0, 1, 0,             0));
    tab.push_back(mk("hilo",    1, WB_HILO, 32'h12345678, 32'hDEADBEEF, 1, 0,  0, 32'h0,            0, 1, hx(32'hDEADBEEF), hx(32'h12345678)));
    tab.push_back(mk("mfhi",    1, WB_MFHI, 32'h999,      32'h0,        1, 0,  1, hx(32'hDEADBEEF), 0, 1, hx(32'hDEADBEEF), hx(32'h12345678)));
    tab.push_back(mk("mflo",    1, WB_MFLO, 32'h0,        32'h0,        1, 0,  1, hx(32'hDEADBEEF), 0, 0, hx(32'hDEADBEEF), hx(32'h12345678)));
    tab.push_back(mk("popmfhi", 0, WB_ALU,  32'h0,        32'h0,        0, 1,  1, hx(32'h12345678), 0, 1, hx(32'hDEADBEEF), hx(32'h12345678)));
    tab.push_back(mk("popmflo", 0, WB_ALU,  32'h0,        32'h0,        0, 1,  0, 32'h0,            0, 1, hx(32'hDEADBEEF), hx(32'h12345678)));
    tab.push_back(mk("pushAA",  1, WB_ALU,  32'hAA,       32'h0,        0, 0,  1, 32'hAA,           0, 1, hx(32'hDEADBEEF), hx(32'h12345678)));
    tab.push_back(mk("ppBB",    1, WB_ALU,  32'hBB,       32'h0,        1, 1,  1, 32'hBB,           1, 1, hx(32'hDEADBEEF), hx(32'h12345678)));
    tab.push_back(mk("nonepop", 1, WB_NONE, 32'h55,       32'h55,       1, 1,  0, 32'h0,            0, 1, hx(32'hDEADBEEF), hx(32'h12345678)));
    tab.push_back(mk("code7",   1, 3'd7,    32'h77,       32'h77,       1, 0,  0, 32'h0,            0, 1, hx(32'hDEADBEEF), hx(32'h12345678)));
    tab.push_back(mk("push66",  1, WB_ALU,  32'h66,       32'h0,        0, 0,  1, 32'h66,           0, 1, hx(32'hDEADBEEF), hx(32'h12345678)));
    tab.push_back(mk("hilopop", 1, WB_HILO, 32'h8,        32'h7,        0, 1,  0, 32'h0,            0, 1, hx(32'h7),        hx(32'h8)));
    tab.push_back(mk("noval",   0, WB_ALU,  32'h77,       32'h0,        1, 0,  0, 32'h0,            0, 1, hx(32'h7),        hx(32'h8)));
    tab.push_back(mk("push1",   1, WB_ALU,  32'h1,        32'h0,        0, 0,  1, 32'h1,            0, 1, hx(32'h7),        hx(32'h8)));
    tab.push_back(mk("push2",   1, WB_ALU,  32'h2,        32'h0,        0, 0,  1, 32'h1,            0, 0, hx(32'h7),        hx(32'h8)));

    #12;
    check_outs(mk("reset", 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tab[i]) apply(tab[i]);

    // asynchronous reset while full: outputs clear without waiting for an edge
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outs(mk("midrst", 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk("rstmfhi", 1, WB_MFHI, 32'h3, 32'h0, 1, 0, 1, 32'h0, 0, 1, 0, 0));
    apply(mk("rstpop",  0, WB_ALU,  32'h0, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 0));

    apply(mk("hiloF",  1, WB_HILO, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, 0, 32'h0, 0, 1,
             hx(32'hFFFFFFFF), hx(32'hFFFFFFFF)));
    apply(mk("mfloF",  1, WB_MFLO, 32'h0, 32'h0, 0, 0, 1, hx(32'hFFFFFFFF), 0, 1,
             hx(32'hFFFFFFFF), hx(32'hFFFFFFFF)));
    apply(mk("drainF", 0, WB_ALU,  32'h0, 32'h0, 0, 1, 0, 32'h0, 0, 1,
             hx(32'hFFFFFFFF), hx(32'hFFFFFFFF)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
